// File: rtl/key_expand_ctrl.sv
// Sequencer for the single-round AES-128 key schedule datapath: steps rounds 1..NUM_ROUNDS,
// captures every round key in a register file and serves them through a registered read port.
`timescale 1ns/1ps
module key_expand_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] ks_key,
  output logic [3:0]       ks_rnum,
  input  logic [KEY_W-1:0] ks_key_next,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  localparam int unsigned NUM_SLOTS = NUM_ROUNDS + 1;
  localparam int unsigned RNUM_W    = 4;

  typedef enum logic {IDLE, EXPAND} stateT;

  stateT            state;
  stateT            stateNext;
  logic             accept;
  logic             stepRound;
  logic             lastRound;
  logic [KEY_W-1:0] slots [NUM_SLOTS];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and round-step decode
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    stepRound = 1'b0;
    lastRound = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = EXPAND;
        end
      end
      EXPAND: begin
        stepRound = 1'b1;
        if (ks_rnum == RNUM_W'(NUM_ROUNDS)) begin
          lastRound = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Working key, round counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_key     <= '0;
      ks_rnum    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      busy <= (stateNext == EXPAND);
      done <= lastRound;
      if (accept) begin
        ks_key     <= key_in;
        ks_rnum    <= RNUM_W'(1);
        keys_valid <= 1'b0;
      end else if (stepRound) begin
        ks_key <= ks_key_next;
        if (lastRound) begin
          ks_rnum    <= '0;
          keys_valid <= 1'b1;
        end else begin
          ks_rnum <= RNUM_W'(ks_rnum + RNUM_W'(1));
        end
      end
    end
  end

  // Round-key register file; slot 0 holds the cipher key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slots[i] <= '0;
    end else if (accept) begin
      slots[0] <= key_in;
    end else if (stepRound) begin
      slots[ks_rnum] <= ks_key_next;
    end
  end

  // Registered read port; the read samples the pre-edge contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rd_key <= '0;
    else if (rd_idx <= RNUM_W'(NUM_ROUNDS)) rd_key <= slots[rd_idx];
    else                                    rd_key <= '0;
  end

endmodule
